// File: rtl/game_flow_sequencer_if.sv
// Bundle between the game flow sequencer and the compositor / enemy-position logic.
// HISCORE_TRACK_EN adds the hiscore field.
interface game_flow_sequencer_if;
    logic       frame_tick;
    logic       btn_start_n;
    logic       btn_pause_n;
    logic       btn_reset_n;
    logic       collision;
    logic [1:0] screen;
    logic [8:0] score;
    logic [1:0] level;
    logic       enemy_step;
    logic       pos_reset;
`ifdef HISCORE_TRACK_EN
    logic [8:0] hiscore;
`endif

    modport master (
        output frame_tick, btn_start_n, btn_pause_n, btn_reset_n, collision,
`ifdef HISCORE_TRACK_EN
        input  hiscore,
`endif
        input  screen, score, level, enemy_step, pos_reset
    );

    modport slave (
        input  frame_tick, btn_start_n, btn_pause_n, btn_reset_n, collision,
`ifdef HISCORE_TRACK_EN
        output hiscore,
`endif
        output screen, score, level, enemy_step, pos_reset
    );
endinterface

// File: rtl/game_flow_sequencer.sv
// TITLE/PLAY/PAUSE/GAMEOVER sequencer with score, level and enemy-advance tick.
// Optional HISCORE_TRACK_EN keeps the best score seen on entry to GAMEOVER.
module game_flow_sequencer #(
    parameter int FRAMES_PER_PT = 60,
    parameter int SCORE_INC     = 10,
    parameter int SCORE_MAX     = 500,
    parameter int DIV_L0        = 4,
    parameter int DIV_L1        = 3,
    parameter int DIV_L2        = 2,
    parameter int DIV_L3        = 1
) (
    input logic                  clock,
    input logic                  reset_n,
    game_flow_sequencer_if.slave bus
);
    localparam int FW = (FRAMES_PER_PT > 1) ? $clog2(FRAMES_PER_PT) : 1;

    typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, GAMEOVER = 2'd3} state_t;

    state_t        state;
    logic [8:0]    score;
    logic [1:0]    level;
    logic          enemy_step;
    logic          pos_reset;
    logic          hit;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    step_cnt;
    logic [2:0]    btn_p0, btn_p1, btn_p2;
    logic [2:0]    press;
    logic          start_press, pause_press, reset_press;
    logic          over_now;

    function automatic logic [8:0] sat_add(input logic [8:0] s);
        logic [9:0] sum;
        sum = {1'b0, s} + 10'(SCORE_INC);
        if (sum >= 10'(SCORE_MAX)) return 9'(SCORE_MAX);
        return sum[8:0];
    endfunction

    function automatic logic [1:0] level_of(input logic [8:0] s);
        if (s < 9'd100) return 2'd0;
        if (s < 9'd200) return 2'd1;
        if (s < 9'd300) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] step_lim(input logic [1:0] lv);
        case (lv)
            2'd0:    return 4'(DIV_L0 - 1);
            2'd1:    return 4'(DIV_L1 - 1);
            2'd2:    return 4'(DIV_L2 - 1);
            default: return 4'(DIV_L3 - 1);
        endcase
    endfunction

    // Buttons: two synchronizer flops, then a history flop for falling-edge detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_p0 <= 3'b000;
            btn_p1 <= 3'b000;
            btn_p2 <= 3'b000;
        end else begin
            btn_p0 <= {bus.btn_reset_n, bus.btn_pause_n, bus.btn_start_n};
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
        end
    end

    assign press       = btn_p2 & ~btn_p1;
    assign reset_press = press[2];
    assign pause_press = press[1];
    assign start_press = press[0];

    assign over_now = (state == PLAY) && !reset_press &&
                      ((bus.frame_tick && (hit || bus.collision)) || (score == 9'(SCORE_MAX)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= TITLE;
            score      <= 9'd0;
            level      <= 2'd0;
            enemy_step <= 1'b0;
            pos_reset  <= 1'b0;
            hit        <= 1'b0;
            frame_cnt  <= '0;
            step_cnt   <= 4'd0;
        end else begin
            pos_reset  <= 1'b0;
            enemy_step <= 1'b0;
            level      <= level_of(score);
            case (state)
                TITLE: begin
                    if (start_press) begin
                        state     <= PLAY;
                        pos_reset <= 1'b1;
                        score     <= 9'd0;
                        frame_cnt <= '0;
                        step_cnt  <= 4'd0;
                        hit       <= 1'b0;
                    end
                end
                PLAY: begin
                    if (reset_press) begin
                        state    <= TITLE;
                        hit      <= 1'b0;
                        step_cnt <= 4'd0;
                    end else if (over_now) begin
                        state    <= GAMEOVER;
                        hit      <= 1'b0;
                        step_cnt <= 4'd0;
                    end else if (pause_press) begin
                        state    <= PAUSE;
                        hit      <= 1'b0;
                        step_cnt <= 4'd0;
                    end else begin
                        if (bus.frame_tick) begin
                            hit <= 1'b0;
                            if (frame_cnt == FW'(FRAMES_PER_PT - 1)) begin
                                frame_cnt <= '0;
                                score     <= sat_add(score);
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end else if (bus.collision) begin
                            hit <= 1'b1;
                        end
                        // The cycle the level register catches up restarts the divider.
                        if (level_of(score) != level) begin
                            step_cnt <= 4'd0;
                        end else if (bus.frame_tick) begin
                            if (step_cnt == step_lim(level)) begin
                                step_cnt   <= 4'd0;
                                enemy_step <= 1'b1;
                            end else begin
                                step_cnt <= step_cnt + 4'd1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (reset_press) begin
                        state <= TITLE;
                    end else if (start_press) begin
                        state <= PLAY;
                    end
                end
                default: begin
                    if (reset_press || start_press) begin
                        state     <= TITLE;
                        pos_reset <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef HISCORE_TRACK_EN
    logic [8:0] hiscore;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hiscore <= 9'd0;
        end else if (over_now && (score > hiscore)) begin
            hiscore <= score;
        end
    end
    assign bus.hiscore = hiscore;
`endif

    assign bus.screen     = state;
    assign bus.score      = score;
    assign bus.level      = level;
    assign bus.enemy_step = enemy_step;
    assign bus.pos_reset  = pos_reset;
endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed bench for game_flow_sequencer: screen flow, score, level, enemy_step, reset.
// Define HISCORE_TRACK_EN to also cover the hiscore output.
module tb_game_flow_sequencer;
    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    game_flow_sequencer_if bus();

    game_flow_sequencer dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            @(negedge clock);
            bus.frame_tick = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic drive_btns(input logic s, input logic p, input logic r);
        bus.btn_start_n = ~s;
        bus.btn_pause_n = ~p;
        bus.btn_reset_n = ~r;
    endtask

    task automatic release_btns();
        drive_btns(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
    endtask

    task automatic do_press(input logic s, input logic p, input logic r);
        drive_btns(s, p, r);
        repeat (6) @(negedge clock);
        release_btns();
    endtask

    task automatic count_steps(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            @(negedge clock);
            bus.frame_tick = 1'b0;
            if (bus.enemy_step === 1'b1) pulses++;
            @(negedge clock);
            if (bus.enemy_step === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.collision  = 1'b0;
        drive_btns(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        tests++; if (bus.screen !== 2'd0) begin fails++; $display("FAIL reset_screen got %0d want 0", bus.screen); end
        tests++; if (bus.score !== 9'd0) begin fails++; $display("FAIL reset_score got %0d want 0", bus.score); end
        tests++; if (bus.level !== 2'd0) begin fails++; $display("FAIL reset_level got %0d want 0", bus.level); end
        tests++; if ({bus.enemy_step, bus.pos_reset} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b want 00", {bus.enemy_step, bus.pos_reset}); end
`ifdef HISCORE_TRACK_EN
        tests++; if (bus.hiscore !== 9'd0) begin fails++; $display("FAIL reset_hiscore got %0d want 0", bus.hiscore); end
`endif
    endtask

    task automatic test_start();
        drive_btns(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        tests++; if (bus.screen !== 2'd0) begin fails++; $display("FAIL start_early got %0d want 0", bus.screen); end
        @(negedge clock);
        tests++; if (bus.screen !== 2'd1) begin fails++; $display("FAIL start_latency got %0d want 1", bus.screen); end
        tests++; if (bus.pos_reset !== 1'b1) begin fails++; $display("FAIL start_pos_reset got %b want 1", bus.pos_reset); end
        tests++; if (bus.score !== 9'd0) begin fails++; $display("FAIL start_score got %0d want 0", bus.score); end
        @(negedge clock);
        tests++; if (bus.pos_reset !== 1'b0) begin fails++; $display("FAIL start_pos_reset_width got %b want 0", bus.pos_reset); end
        release_btns();
        frames(59);
        tests++; if (bus.score !== 9'd0) begin fails++; $display("FAIL score_59_ticks got %0d want 0", bus.score); end
        frames(1);
        tests++; if (bus.score !== 9'd10) begin fails++; $display("FAIL score_60_ticks got %0d want 10", bus.score); end
    endtask

    task automatic test_enemy_step();
        int pulses;
        count_steps(8, pulses);
        tests++; if (pulses !== 2) begin fails++; $display("FAIL step_level0 got %0d want 2", pulses); end
    endtask

    task automatic test_pause();
        int pulses;
        do_press(1'b0, 1'b1, 1'b0);
        tests++; if (bus.screen !== 2'd2) begin fails++; $display("FAIL pause_enter got %0d want 2", bus.screen); end
        count_steps(120, pulses);
        tests++; if (pulses !== 0) begin fails++; $display("FAIL pause_steps got %0d want 0", pulses); end
        tests++; if (bus.score !== 9'd10) begin fails++; $display("FAIL pause_score got %0d want 10", bus.score); end
        bus.collision = 1'b1;
        @(negedge clock);
        bus.collision = 1'b0;
        frames(1);
        tests++; if (bus.screen !== 2'd2) begin fails++; $display("FAIL pause_collision got %0d want 2", bus.screen); end
        do_press(1'b1, 1'b0, 1'b0);
        tests++; if (bus.screen !== 2'd1) begin fails++; $display("FAIL resume got %0d want 1", bus.screen); end
        tests++; if (bus.score !== 9'd10) begin fails++; $display("FAIL resume_score got %0d want 10", bus.score); end
        frames(1);
        tests++; if (bus.screen !== 2'd1) begin fails++; $display("FAIL resume_no_hit got %0d want 1", bus.screen); end
    endtask

    task automatic test_collision();
        bus.collision = 1'b1;
        @(negedge clock);
        bus.collision = 1'b0;
        repeat (3) @(negedge clock);
        tests++; if (bus.screen !== 2'd1) begin fails++; $display("FAIL hit_before_tick got %0d want 1", bus.screen); end
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        tests++; if (bus.screen !== 2'd3) begin fails++; $display("FAIL hit_gameover got %0d want 3", bus.screen); end
        tests++; if (bus.score !== 9'd10) begin fails++; $display("FAIL hit_score got %0d want 10", bus.score); end
        drive_btns(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        tests++; if ({bus.screen, bus.pos_reset} !== 3'b001) begin fails++; $display("FAIL over_to_title got %b want 001", {bus.screen, bus.pos_reset}); end
        release_btns();
    endtask

    task automatic test_start_reset_same();
        do_press(1'b1, 1'b0, 1'b0);
        tests++; if (bus.screen !== 2'd1) begin fails++; $display("FAIL replay got %0d want 1", bus.screen); end
        do_press(1'b1, 1'b0, 1'b1);
        tests++; if (bus.screen !== 2'd0) begin fails++; $display("FAIL start_reset_title got %0d want 0", bus.screen); end
    endtask

    task automatic test_level_and_async_reset();
        int pulses;
        do_press(1'b1, 1'b0, 1'b0);
        frames(599);
        tests++; if (bus.score !== 9'd90) begin fails++; $display("FAIL score_90 got %0d want 90", bus.score); end
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        tests++; if ({bus.score, bus.level} !== {9'd100, 2'd0}) begin fails++; $display("FAIL level_lag got %0d/%0d want 100/0", bus.score, bus.level); end
        @(negedge clock);
        tests++; if (bus.level !== 2'd1) begin fails++; $display("FAIL level1 got %0d want 1", bus.level); end
        frames(120);
        count_steps(6, pulses);
        tests++; if (pulses !== 2) begin fails++; $display("FAIL step_level1 got %0d want 2", pulses); end
        tests++; if (bus.score !== 9'd120) begin fails++; $display("FAIL score_120 got %0d want 120", bus.score); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if ({bus.screen, bus.score, bus.level, bus.enemy_step, bus.pos_reset} !== 15'd0) begin fails++; $display("FAIL async_reset got s=%0d sc=%0d l=%0d", bus.screen, bus.score, bus.level); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        tests++; if (bus.screen !== 2'd0) begin fails++; $display("FAIL after_reset got %0d want 0", bus.screen); end
    endtask

    task automatic test_win();
        int pulses;
        do_press(1'b1, 1'b0, 1'b0);
        frames(1800);
        tests++; if ({bus.score, bus.level} !== {9'd300, 2'd3}) begin fails++; $display("FAIL score_300 got %0d/%0d want 300/3", bus.score, bus.level); end
        count_steps(4, pulses);
        tests++; if (pulses !== 4) begin fails++; $display("FAIL step_level3 got %0d want 4", pulses); end
        frames(1136 + 59);
        tests++; if ({bus.screen, bus.score} !== {2'd1, 9'd490}) begin fails++; $display("FAIL score_490 got %0d/%0d want 1/490", bus.screen, bus.score); end
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        tests++; if ({bus.screen, bus.score} !== {2'd1, 9'd500}) begin fails++; $display("FAIL score_500 got %0d/%0d want 1/500", bus.screen, bus.score); end
        @(negedge clock);
        tests++; if (bus.screen !== 2'd3) begin fails++; $display("FAIL win_gameover got %0d want 3", bus.screen); end
        frames(60);
        tests++; if (bus.score !== 9'd500) begin fails++; $display("FAIL score_held got %0d want 500", bus.score); end
`ifdef HISCORE_TRACK_EN
        tests++; if (bus.hiscore !== 9'd500) begin fails++; $display("FAIL hiscore got %0d want 500", bus.hiscore); end
`endif
        do_press(1'b0, 1'b0, 1'b1);
        tests++; if (bus.screen !== 2'd0) begin fails++; $display("FAIL win_to_title got %0d want 0", bus.screen); end
`ifdef HISCORE_TRACK_EN
        tests++; if (bus.hiscore !== 9'd500) begin fails++; $display("FAIL hiscore_kept got %0d want 500", bus.hiscore); end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_start();
        test_enemy_step();
        test_pause();
        test_collision();
        test_start_reset_same();
        test_level_and_async_reset();
        test_win();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
